aes_ctr_stream: RTL



---
 rtl/aes_ctr_stream.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/aes_ctr_stream.sv
// AES-CTR stream controller: issues counter blocks to the cipher core and XORs the keystream into buffered beats.
// Accept-to-output latency is core latency + 2; credits drop o_ready at DEPTH outstanding, i_ready stalls the output.
module aes_ctr_stream #(
    parameter int WORD     = 32,
    parameter int NB       = 4,
    parameter int CTR_BITS = 32,
    parameter int DEPTH    = 8,
    parameter int WRAP     = 0,
    localparam int BW      = WORD * NB,
    localparam int NBY     = BW / 8
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           i_start,
    input  logic [BW-1:0]  i_nonce,
    output logic           o_busy,
    input  logic           i_valid,
    output logic           o_ready,
    input  logic [BW-1:0]  i_block,
    input  logic [NBY-1:0] i_strb,
    input  logic           i_last,
    output logic           o_core_valid,
    output logic [BW-1:0]  o_core_block,
    input  logic           i_core_valid,
    input  logic [BW-1:0]  i_core_block,
    output logic           o_valid,
    input  logic           i_ready,
    output logic [BW-1:0]  o_block,
    output logic [NBY-1:0] o_strb,
    output logic           o_last,
    output logic           o_ctr_wrap
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int DW = BW + NBY + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t         r_state;
    state_t         w_state_nxt;
    logic [CW-1:0]  r_credits;
    logic [BW-1:0]  r_ctr;
    logic [BW-1:0]  w_ctr_inc;
    logic           w_fld_wrap;
    logic           r_wrap;
    logic           r_core_vld;
    logic [BW-1:0]  r_core_blk;

    logic [DW-1:0]  r_dmem [DEPTH];
    logic [BW-1:0]  r_kmem [DEPTH];
    logic [AW-1:0]  r_dwp, r_drp, r_kwp, r_krp;
    logic [CW-1:0]  r_dcnt, r_kcnt;

    logic           w_rdy;
    logic           w_acc;
    logic           w_pop;
    logic           w_kpush;
    logic [DW-1:0]  w_dhead;
    logic [BW-1:0]  w_khead;
    logic [BW-1:0]  w_dblk;
    logic [NBY-1:0] w_dstrb;

    assign w_rdy   = (r_state == S_RUN) && (r_credits != '0);
    assign w_acc   = i_valid && w_rdy;
    assign o_valid = (r_dcnt != '0) && (r_kcnt != '0);
    assign w_pop   = o_valid && i_ready;
    // Responses landing in IDLE belong to an aborted message and are dropped.
    assign w_kpush = i_core_valid && (r_state != S_IDLE);

    assign o_ready      = w_rdy;
    assign o_busy       = (r_state != S_IDLE);
    assign o_core_valid = r_core_vld;
    assign o_core_block = r_core_blk;
    assign o_ctr_wrap   = r_wrap;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_RUN;
            S_RUN:   if (w_acc && i_last) w_state_nxt = S_DRAIN;
            S_DRAIN: if (r_dcnt == '0 && r_credits == CW'(DEPTH)) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_ctr_inc  = r_ctr;
        w_fld_wrap = 1'b0;
        if (WRAP != 0) begin
            w_ctr_inc = r_ctr + BW'(1);
        end else begin
            w_ctr_inc[CTR_BITS-1:0] = r_ctr[CTR_BITS-1:0] + CTR_BITS'(1);
            w_fld_wrap              = &r_ctr[CTR_BITS-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_ctr      <= '0;
            r_wrap     <= 1'b0;
            r_core_vld <= 1'b0;
            r_core_blk <= '0;
            r_credits  <= CW'(DEPTH);
        end else begin
            r_state    <= w_state_nxt;
            r_core_vld <= w_acc;
            if (w_acc) r_core_blk <= r_ctr;
            if (r_state == S_IDLE && i_start) begin
                r_ctr  <= i_nonce;
                r_wrap <= 1'b0;
            end else if (w_acc) begin
                r_ctr <= w_ctr_inc;
                if (w_fld_wrap) r_wrap <= 1'b1;
            end
            case ({w_acc, w_pop})
                2'b10:   r_credits <= r_credits - CW'(1);
                2'b01:   r_credits <= r_credits + CW'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Credits bound both FIFOs to DEPTH entries, so no full checks are needed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dwp  <= '0;
            r_drp  <= '0;
            r_kwp  <= '0;
            r_krp  <= '0;
            r_dcnt <= '0;
            r_kcnt <= '0;
        end else begin
            if (w_acc)   r_dwp <= r_dwp + AW'(1);
            if (w_kpush) r_kwp <= r_kwp + AW'(1);
            if (w_pop) begin
                r_drp <= r_drp + AW'(1);
                r_krp <= r_krp + AW'(1);
            end
            r_dcnt <= r_dcnt + CW'(w_acc) - CW'(w_pop);
            r_kcnt <= r_kcnt + CW'(w_kpush) - CW'(w_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (w_acc)   r_dmem[r_dwp] <= {i_block, i_strb, i_last};
        if (w_kpush) r_kmem[r_kwp] <= i_core_block;
    end

    assign w_dhead = r_dmem[r_drp];
    assign w_khead = r_kmem[r_krp];
    assign w_dblk  = w_dhead[DW-1:NBY+1];
    assign w_dstrb = w_dhead[NBY:1];
    assign o_strb  = w_dstrb;
    assign o_last  = w_dhead[0];

    always_comb begin
        o_block = '0;
        for (int k = 0; k < NBY; k++) begin
            if (w_dstrb[k]) o_block[8*k +: 8] = w_dblk[8*k +: 8] ^ w_khead[8*k +: 8];
        end
    end

endmodule
